// File: rtl/fir_decim_stage2.sv
// Decimate-by-DECIM FIR stage: TAPS-deep delay line, snapshot on every DECIM-th sample,
// and a time-multiplexed MAC that evaluates TAPS/DECIM taps per beat over DECIM beats.
module fir_decim_stage2 #(
  parameter int TAPS  = 16,
  parameter int DECIM = 4,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DW-1:0]           data_in,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  output logic [DW-1:0]           data_out,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int AW  = $clog2(TAPS);
  localparam int MPB = TAPS / DECIM;
  localparam int PW  = DW + CW;
  localparam int BW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [BW-1:0] LAST = BW'(DECIM - 1);
  localparam logic signed [ACCW-1:0] RND     = ACCW'(64'sd1 <<< (CW - 2));
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(64'sd1 <<< (DW - 1)));

  typedef enum logic {ST_IDLE, ST_MAC} state_t;

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    x_q [TAPS];
  logic signed [DW-1:0]    x_d [TAPS];
  logic signed [DW-1:0]    s_q [TAPS];
  logic signed [DW-1:0]    s_d [TAPS];
  logic signed [CW-1:0]    h_q [TAPS];
  logic signed [CW-1:0]    h_d [TAPS];
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [BW-1:0]           phase_q, phase_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic signed [DW-1:0]    data_out_q, data_out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    trigger;
  logic [AW-1:0]           tap_idx;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  beat_sum, final_sum, rounded;
  logic signed [DW-1:0]    sat;

  assign trigger   = in_valid && (phase_q == LAST);
  assign busy      = (state_q == ST_MAC);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

  // One beat covers taps beat*MPB .. beat*MPB+MPB-1 of the frozen snapshot.
  always_comb begin
    beat_sum = '0;
    tap_idx  = '0;
    prod     = '0;
    for (int j = 0; j < MPB; j++) begin
      tap_idx  = AW'(int'(beat_q) * MPB + j);
      prod     = PW'(s_q[tap_idx]) * PW'(h_q[tap_idx]);
      beat_sum = beat_sum + ACCW'(prod);
    end
    final_sum = acc_q + beat_sum;
    rounded   = (final_sum + RND) >>> (CW - 1);
    if (rounded > SAT_MAX) begin
      sat = DW'(SAT_MAX);
    end else if (rounded < SAT_MIN) begin
      sat = DW'(SAT_MIN);
    end else begin
      sat = DW'(rounded);
    end
  end

  always_comb begin
    x_d         = x_q;
    s_d         = s_q;
    h_d         = h_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    beat_d      = beat_q;
    state_d     = state_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;

    if (in_valid) begin
      x_d[0] = $signed(data_in);
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      phase_d = trigger ? '0 : phase_q + 1'b1;
    end

    if (coef_we && (state_q == ST_IDLE)) begin
      h_d[coef_addr] = $signed(coef_data);
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d  = final_sum;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST) begin
          data_out_d  = sat;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A trigger on the final beat restarts the MAC on a fresh snapshot.
    if (trigger) begin
      s_d     = x_d;
      acc_d   = '0;
      beat_d  = '0;
      state_d = ST_MAC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        s_q[k] <= '0;
        h_q[k] <= '0;
      end
      acc_q       <= '0;
      phase_q     <= '0;
      beat_q      <= '0;
      state_q     <= ST_IDLE;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      s_q         <= s_d;
      h_q         <= h_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      beat_q      <= beat_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fir_decim_stage2.sv
// Directed bench for fir_decim_stage2: impulse, saturation, rounding, rate/gaps,
// coefficient write gating and reset during a MAC.
module tb_fir_decim_stage2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] data_in;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] data_out;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bphase = 0;
  int consec = 0;
  logic prev_ov = 1'b0;

  logic signed [31:0] out_q [$];
  int out_cyc_q [$];
  int trig_q [$];

  fir_decim_stage2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output pulses are captured mid-cycle together with the edge count that produced them.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      out_q.push_back(32'($signed(data_out)));
      out_cyc_q.push_back(cyc);
      if (prev_ov === 1'b1) consec++;
    end
    prev_ov = out_valid;
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic signed [15:0] d, input logic we,
                               input logic [3:0] a, input logic signed [15:0] cd);
    in_valid  = v;
    data_in   = d;
    coef_we   = we;
    coef_addr = a;
    coef_data = cd;
    @(posedge clk);
    #1;
    if (v) begin
      if (bphase == 3) begin
        trig_q.push_back(cyc);
        bphase = 0;
      end else begin
        bphase++;
      end
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic feed(input logic signed [15:0] d);
    applyStimulus(1'b1, d, 1'b0, 4'd0, 16'sd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'sd0, 1'b0, 4'd0, 16'sd0);
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [15:0] cd);
    applyStimulus(1'b0, 16'sd0, 1'b1, a, cd);
  endtask

  task automatic clear_logs();
    out_q.delete();
    out_cyc_q.delete();
    trig_q.delete();
  endtask

  function automatic logic signed [31:0] get_out(input int i);
    if (i < out_q.size()) return out_q[i];
    return 'x;
  endfunction

  function automatic logic signed [31:0] get_cyc(input int i);
    if (i < out_cyc_q.size()) return out_cyc_q[i];
    return 'x;
  endfunction

  function automatic logic signed [31:0] get_trig(input int i);
    if (i < trig_q.size()) return trig_q[i];
    return 'x;
  endfunction

  initial begin
    logic signed [31:0] imp_exp [5];
    logic signed [31:0] neg_exp [6];
    imp_exp = '{2048, 4096, 6144, 8192, 0};
    neg_exp = '{32767, -8, -32768, -32768, -32768, -32768};

    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // Impulse response with h[k] = 1024*(k+1)
    for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(1024 * (k + 1)));
    clear_logs();
    feed(16'sd16384);
    for (int i = 0; i < 19; i++) feed(16'sd0);
    idle(8);
    checkOutput("impulse_count", out_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("impulse_val%0d", i), get_out(i), imp_exp[i]);
      checkOutput($sformatf("impulse_lat%0d", i), get_cyc(i), get_trig(i) + 4);
    end

    // Saturation, positive then negative
    for (int k = 0; k < 16; k++) write_coef(4'(k), 16'sd32767);
    clear_logs();
    for (int i = 0; i < 16; i++) feed(16'sd32767);
    idle(8);
    checkOutput("sat_pos_count", out_q.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("sat_pos%0d", i), get_out(i), 32767);
    clear_logs();
    for (int i = 0; i < 24; i++) feed(-16'sd32768);
    idle(8);
    checkOutput("sat_neg_count", out_q.size(), 6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("sat_neg%0d", i), get_out(i), neg_exp[i]);

    // Rounding with h[0]=1, others 0
    for (int k = 0; k < 16; k++) write_coef(4'(k), (k == 0) ? 16'sd1 : 16'sd0);
    clear_logs();
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16384);
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(-16'sd16384);
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16383);
    idle(8);
    checkOutput("round_count", out_q.size(), 3);
    checkOutput("round_half_up", get_out(0), 1);
    checkOutput("round_neg_half", get_out(1), 0);
    checkOutput("round_below_half", get_out(2), 0);

    // Coefficient writes gated by busy
    clear_logs();
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16384);
    checkOutput("busy_after_trigger", busy, 1);
    applyStimulus(1'b0, 16'sd0, 1'b1, 4'd0, 16'sd16384);
    idle(6);
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16384);
    idle(6);
    checkOutput("busy_idle", busy, 0);
    write_coef(4'd0, 16'sd16384);
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16384);
    idle(6);
    feed(16'sd0); feed(16'sd0); feed(16'sd0);
    applyStimulus(1'b1, 16'sd16384, 1'b1, 4'd0, 16'sd1);
    idle(6);
    checkOutput("cw_count", out_q.size(), 4);
    checkOutput("cw_dropped_now", get_out(0), 1);
    checkOutput("cw_dropped_next", get_out(1), 1);
    checkOutput("cw_applied", get_out(2), 8192);
    checkOutput("cw_on_trigger", get_out(3), 1);

    // Rate: continuous input, then irregular gaps
    clear_logs();
    for (int i = 0; i < 64; i++) begin
      feed(16'sd16384);
      if (i == 40) checkOutput("busy_continuous", busy, 1);
    end
    for (int i = 0; i < 32; i++) begin
      feed(16'sd16384);
      idle(((i * 3) % 5) + 1);
    end
    idle(8);
    checkOutput("rate_out_count", out_q.size(), 24);
    checkOutput("rate_trig_count", trig_q.size(), 24);
    for (int i = 0; i < 24; i++)
      checkOutput($sformatf("rate_lat%0d", i), get_cyc(i), get_trig(i) + 4);

    // Reset at beat 2 of a running MAC
    clear_logs();
    feed(16'sd0); feed(16'sd0); feed(16'sd0); feed(16'sd16384);
    feed(16'sd0); feed(16'sd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bphase = 0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_busy", busy, 0);
    idle(6);
    checkOutput("rst_no_output", out_q.size(), 0);
    clear_logs();
    feed(16'sd16384); feed(16'sd16384); feed(16'sd16384);
    checkOutput("rst_no_early_trigger", busy, 0);
    feed(16'sd16384);
    checkOutput("rst_trigger_4th", busy, 1);
    idle(6);
    checkOutput("rst_post_count", out_q.size(), 1);
    checkOutput("rst_coef_cleared", get_out(0), 0);
    checkOutput("rst_post_lat", get_cyc(0), get_trig(0) + 4);

    checkOutput("no_consecutive_out_valid", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_stage2.md
# fir_decim_stage2

Decimate-by-4 FIR stage for the return path of the wavelength-locker DSP chain, the mirror of the ×4 interpolation stage. It accepts one 16-bit signed sample per `in_valid` strobe and keeps a TAPS-deep delay line. On every 4th accepted sample it computes one filtered output over DECIM clock cycles using a time-multiplexed MAC with TAPS/DECIM multipliers. Coefficients are runtime-writable Q1.15 values.

## Interface
- `TAPS`, 16: filter length; must be a multiple of DECIM.
- `DECIM`, 4: decimation factor, which is also the MAC beat count.
- `DW`, 16: sample width (signed).
- `CW`, 16: coefficient width (signed, Q1.15).
- `ACCW`, 36: accumulator width (signed).

- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `data_in`  in  DW  input sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  clog2(TAPS)  tap index.
- `coef_data`  in  CW  coefficient value.
- `data_out`  out  DW  decimated output, held between updates.
- `out_valid`  out  1  one-cycle pulse when `data_out` updates.
- `busy`  out  1  MAC in progress.

## Operation
- Reset: synchronous, taken only on a `clk` edge with `rst_n`=0. It clears the delay line, snapshot, coefficients, accumulator, phase counter and beat counter. `data_out`=0, `out_valid`=0, `busy`=0.
- Delay line: on `in_valid`, x[0]←`data_in` and x[k]←x[k-1].
- Phase counter: 0..DECIM-1, increments on `in_valid` and wraps to 0.
  - Trigger = `in_valid` && phase==DECIM-1.
- On trigger, in the same edge:
  - the snapshot s[k] is loaded with the post-shift delay line (s[0]=new sample);
  - acc←0, beat←0, `busy`←1.
- FSM has two states.
  - IDLE: `busy`=0. Trigger → MAC.
  - MAC: beat b (0..DECIM-1) adds the TAPS/DECIM products s[k]·h[k] for k=b·TAPS/DECIM .. (b+1)·TAPS/DECIM−1. The beat counter increments each edge.
  - At beat DECIM-1, the final sum is acc plus this beat's products. It is rounded and saturated and registered into `data_out`, `out_valid`←1.
  - Then return to IDLE, or if a trigger coincides with that edge, re-enter MAC with beat=0, acc=0 and a fresh snapshot.
- Arithmetic:
  - products are DW+CW=32 bits signed;
  - accumulate in ACCW, sign-extended;
  - round half-up: add 2^(CW-2)=16384, then arithmetic shift right by CW-1=15;
  - saturate to [−32768, 32767].
- Coefficients:
  - `coef_we` with `busy`=0 writes h[`coef_addr`]←`coef_data` at the edge;
  - writes while `busy`=1 are dropped;
  - a write in the same cycle as a trigger is accepted, because `busy` is still 0.
- `in_valid` during MAC is accepted normally. The delay line and phase advance; the snapshot isolates the running MAC.

## Timing
- Trigger at edge T.
  - Beats at edges T+1..T+DECIM.
  - `data_out`/`out_valid` update at edge T+4.
  - `out_valid` is high for exactly the cycle after T+4.
- Latency: 4 clocks from the trigger sample to `out_valid`.
- Throughput: `in_valid` every cycle is supported, giving one `out_valid` per 4 inputs with period exactly 4 clocks. Back-to-back triggers (T+4 = next trigger) are lossless.
- `busy` is high from edge T through edge T+4 when there is no new trigger. With continuous input it is high continuously.
- `rst_n` low during MAC: the pending output is discarded (no `out_valid`) and all state returns to reset values at that edge.

## Test plan
- Impulse response:
  - stimulus: h[k]=1024·(k+1); inputs 16384, then 19 zeros, all with `in_valid`=1 every cycle;
  - required: `out_valid` pulses carry 2048, 4096, 6144, 8192, then 0.
- Saturation:
  - stimulus: all h=32767, constant input 32767;
  - required: steady outputs 32767.
  - stimulus: same coefficients, constant input −32768;
  - required: outputs −32768 with no wrap.
- Rounding:
  - stimulus: h[0]=1, others 0;
  - required: input 16384 on the trigger sample → 1; input −16384 → 0; input 16383 → 0.
- Rate and gaps:
  - stimulus: `in_valid` every cycle for 64 cycles, then irregular gaps of 1–5 cycles;
  - required: exactly one `out_valid` per 4 accepted samples, 4 clocks after each trigger, and `out_valid` never high on 2 consecutive cycles.
- Coefficient write while busy:
  - stimulus: write h[0]=16384 during MAC;
  - required: the write is dropped and the current and next outputs use the old h[0].
  - stimulus: repeat the write with `busy`=0;
  - required: the write is applied on the next trigger.
- Reset mid-MAC:
  - stimulus: drop `rst_n` for 1 cycle at beat 2;
  - required: no `out_valid`; `data_out`=0, `busy`=0, coefficients=0; the next trigger occurs on the 4th sample after reset.
